// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared constants and state type for the SPI peripheral
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } spi_per_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_peripheral_if.sv
// ============================================================================
// spi_peripheral_if : SPI pins plus local word interface of the peripheral
// Rev 1.0
// ============================================================================
`default_nettype none

interface spi_peripheral_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_WORD_W
);

  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  sclk, cs, mosi, tx_data,
    output miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output sclk, cs, mosi, tx_data,
    input  miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : multi-flop pin synchronizer with rise/fall pulse outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_peripheral.sv
// ============================================================================
// spi_peripheral : mode-0, MSB-first SPI slave, pins oversampled on sysclk
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_peripheral
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic            sysclk,
  input  logic            rst,
  spi_peripheral_if.slave bus
);

  localparam int C_CNT_W = $clog2(DATA_WIDTH + 2);
  localparam int C_ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(DATA_WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_SAT  = C_CNT_W'(DATA_WIDTH + 1);
  localparam logic [C_ARM_W-1:0] C_ARM_DONE = C_ARM_W'(SYNC_STAGES);

  logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi_level, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(sysclk), .rst(rst), .din(bus.sclk),
    .level(w_sclk_level_unused), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(sysclk), .rst(rst), .din(bus.cs),
    .level(w_cs_level), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(sysclk), .rst(rst), .din(bus.mosi),
    .level(w_mosi_level), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
  );

  spi_per_state_t        r_state, w_state_nxt;
  logic [C_ARM_W-1:0]    r_arm_cnt, w_arm_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [DATA_WIDTH-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [C_CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic                  r_miso_oe, w_miso_oe_nxt;
  logic                  r_busy, w_busy_nxt;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state     <= ARMED;
      r_arm_cnt   <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_arm_cnt   <= w_arm_cnt_nxt;
      r_tx_sh     <= w_tx_sh_nxt;
      r_rx_sh     <= w_rx_sh_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_miso_oe   <= w_miso_oe_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_arm_cnt_nxt   = r_arm_cnt;
    w_tx_sh_nxt     = r_tx_sh;
    w_rx_sh_nxt     = r_rx_sh;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_miso_oe_nxt   = r_miso_oe;
    w_busy_nxt      = r_busy;
    case (r_state)
      // The cs synchronizer starts at its reset level, so only trust a high cs
      // once every flop has been refilled from the pin.
      ARMED: begin
        if (!w_cs_level) begin
          w_arm_cnt_nxt = '0;
        end else if (r_arm_cnt == C_ARM_DONE) begin
          w_arm_cnt_nxt = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_arm_cnt_nxt = r_arm_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt   = ACTIVE;
          w_tx_sh_nxt   = bus.tx_data;
          w_bit_cnt_nxt = '0;
          w_miso_oe_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt   = IDLE;
          w_tx_sh_nxt   = '0;
          w_miso_oe_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          if (r_bit_cnt == C_CNT_FULL) begin
            w_rx_data_nxt  = r_rx_sh;
            w_rx_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else if (w_sclk_rise) begin
          w_rx_sh_nxt = {r_rx_sh[DATA_WIDTH-2:0], w_mosi_level};
          if (r_bit_cnt != C_CNT_SAT) begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
          w_tx_sh_nxt = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
        end
      end
      default: w_state_nxt = ARMED;
    endcase
  end

  // miso is the registered MSB of the transmit shifter, cleared outside frames
  assign bus.miso      = r_tx_sh[DATA_WIDTH-1];
  assign bus.miso_oe   = r_miso_oe;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire
